// File: rtl/aes_cbc_sched.sv
// Block-mode scheduler between a 128-bit streaming interface and an AES core.
// Drives key expansion and per-block start through the core handshake, applies ECB or CBC
// chaining in either direction and holds one finished block behind a valid/ready port.
// A cycle counter guards KEYEXP and WAIT against a core that never answers.
module aes_cbc_sched #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,

    // Configuration
    input  logic         cfg_key_load,
    input  logic [255:0] cfg_key,
    input  logic         cfg_keylen,
    input  logic         cfg_mode,
    input  logic         cfg_encdec,
    input  logic         cfg_iv_load,
    input  logic [127:0] cfg_iv,

    // Status
    output logic         key_ready,
    output logic         busy,
    output logic         err,

    // Input block stream
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_last,

    // Output block stream
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_last,

    // AES core side
    output logic         core_init,
    output logic         core_next,
    output logic         core_encdec,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic         core_result_valid,
    input  logic [127:0] core_result
);

    typedef enum logic [2:0] {
        StIdle,
        StKeyexp,
        StReady,
        StStart,
        StWait,
        StOut
    } state_e;

    // The counter sits at TIMEOUT_CYC-1 in the last cycle before err is raised, so err
    // becomes visible exactly TIMEOUT_CYC cycles after KEYEXP/WAIT entry.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 32'd1);

    state_e       state_q;
    logic         mode_q;       // 0 = ECB, 1 = CBC
    logic [127:0] iv_q;
    logic [127:0] chain_q;      // previous ciphertext (or IV) used for CBC chaining
    logic [127:0] save_in_q;    // raw input block, becomes the chain value in CBC decrypt
    logic         last_q;
    logic [7:0]   cnt_q;

    logic cfg_open;
    logic key_go;
    logic iv_go;
    logic s_fire;
    logic timeout;

    assign cfg_open = (state_q == StIdle) || (state_q == StReady);
    assign key_go   = cfg_open && cfg_key_load;
    assign iv_go    = cfg_open && cfg_iv_load;
    assign timeout  = (cnt_q == TimeoutLast);

    // A key load in READY takes the cycle, so no block is offered a handshake it would lose.
    assign s_ready  = (state_q == StReady) && !cfg_key_load;
    assign s_fire   = s_valid && s_ready;

    assign m_valid  = (state_q == StOut);
    assign busy     = (state_q == StKeyexp) || (state_q == StStart) ||
                      (state_q == StWait)   || (state_q == StOut);

    // Scheduler FSM together with all datapath registers and registered core/stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            iv_q        <= '0;
            chain_q     <= '0;
            save_in_q   <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            key_ready   <= 1'b0;
            err         <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_encdec <= 1'b0;
            core_keylen <= 1'b0;
            core_key    <= '0;
            core_block  <= '0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;

            if (iv_go) begin
                iv_q <= cfg_iv;
            end

            unique case (state_q)
                StIdle, StReady: begin
                    if (key_go) begin
                        core_key    <= cfg_key;
                        core_keylen <= cfg_keylen;
                        core_encdec <= cfg_encdec;
                        mode_q      <= cfg_mode;
                        // A same-cycle IV load is the newer value.
                        chain_q     <= iv_go ? cfg_iv : iv_q;
                        err         <= 1'b0;
                        key_ready   <= 1'b0;
                        core_init   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StKeyexp;
                    end else begin
                        if (iv_go) begin
                            chain_q <= cfg_iv;
                        end
                        if (s_fire) begin
                            core_block <= (mode_q && core_encdec) ? (s_data ^ chain_q) : s_data;
                            save_in_q  <= s_data;
                            last_q     <= s_last;
                            // core_next is high for the single START cycle.
                            core_next  <= 1'b1;
                            state_q    <= StStart;
                        end
                    end
                end

                StKeyexp: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (core_ready) begin
                        key_ready <= 1'b1;
                        state_q   <= StReady;
                    end else if (timeout) begin
                        err       <= 1'b1;
                        key_ready <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end

                StWait: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (core_result_valid) begin
                        m_last  <= last_q;
                        state_q <= StOut;
                        if (mode_q && !core_encdec) begin
                            m_data  <= core_result ^ chain_q;
                            chain_q <= save_in_q;
                        end else begin
                            m_data <= core_result;
                            if (mode_q) begin
                                chain_q <= core_result;
                            end
                        end
                    end else if (timeout) begin
                        // The in-flight block is abandoned; a fresh key load is required.
                        err       <= 1'b1;
                        key_ready <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                StOut: begin
                    if (m_ready) begin
                        state_q <= StReady;
                        if (m_last) begin
                            chain_q <= iv_q;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_sched.sv
// Self-checking bench for aes_cbc_sched: a behavioural AES-core stand-in, a block-mode
// reference model with an expected-output queue, and a compare process on the output port.
`timescale 1ns/1ps
module tb_aes_cbc_sched;

    localparam int unsigned TO = 16;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K2  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV3 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_key_load;
    logic [255:0] cfg_key;
    logic         cfg_keylen;
    logic         cfg_mode;
    logic         cfg_encdec;
    logic         cfg_iv_load;
    logic [127:0] cfg_iv;
    logic         key_ready;
    logic         busy;
    logic         err;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;
    logic         core_init;
    logic         core_next;
    logic         core_encdec;
    logic         core_keylen;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_ready;
    logic         core_result_valid;
    logic [127:0] core_result;

    aes_cbc_sched #(
        .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_key_load     (cfg_key_load),
        .cfg_key          (cfg_key),
        .cfg_keylen       (cfg_keylen),
        .cfg_mode         (cfg_mode),
        .cfg_encdec       (cfg_encdec),
        .cfg_iv_load      (cfg_iv_load),
        .cfg_iv           (cfg_iv),
        .key_ready        (key_ready),
        .busy             (busy),
        .err              (err),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .core_init        (core_init),
        .core_next        (core_next),
        .core_encdec      (core_encdec),
        .core_keylen      (core_keylen),
        .core_key         (core_key),
        .core_block       (core_block),
        .core_ready       (core_ready),
        .core_result_valid(core_result_valid),
        .core_result      (core_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Core stand-in controls and observations
    bit core_ready_en  = 1'b1;
    bit core_result_en = 1'b1;
    int rlat_fix       = 0;     // 0 = random result latency
    int kready_cyc     = -1;
    int n_next         = 0;
    int stall_n        = -1;    // -1 = random output backpressure

    // Reference model state
    logic [255:0] md_key;
    logic         md_kl;
    logic         md_mode;
    logic         md_enc;
    logic [127:0] md_iv    = '0;
    logic [127:0] md_chain = '0;
    logic [127:0] exp_data[$];
    logic         exp_last[$];
    logic [127:0] outs[$];
    logic         outs_last[$];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behaviour of the AES core: published vectors where the tests need them, otherwise a
    // keyed mixing function that depends on key, key length and direction.
    function automatic logic [127:0] core_fn(input logic [255:0] k, input logic kl,
                                             input logic enc, input logic [127:0] b);
        logic [127:0] kk;
        if (!kl && enc && k[255:128] == K1 && b == PT0) return CT1;
        if (kl && !enc && k == K2 && b == CT2) return PT0;
        if (!kl && k[255:128] == K3) begin
            if (enc && b == (P1 ^ IV3)) return C1;
            if (enc && b == (P2 ^ C1)) return C2;
            if (!enc && b == C1) return P1 ^ IV3;
            if (!enc && b == C2) return P2 ^ C1;
        end
        kk = kl ? (k[255:128] ^ {k[63:0], k[127:64]}) : k[255:128];
        return {b[100:0], b[127:101]} ^ kk ^
               (enc ? 128'h3c3c_1234_5678_9abc_def0_0f0f_a5a5_5a5a
                    : 128'hc3c3_8765_4321_0fed_cba9_f0f0_5a5a_a5a5);
    endfunction

    // Block-mode rules applied to one accepted block; returns the block the core must see.
    function automatic logic [127:0] model_push(input logic [127:0] d, input logic last);
        logic [127:0] cin;
        logic [127:0] r;
        logic [127:0] e;
        cin = (md_mode && md_enc) ? (d ^ md_chain) : d;
        r   = core_fn(md_key, md_kl, md_enc, cin);
        if (!md_mode) begin
            e = r;
        end else if (md_enc) begin
            e = r;
            md_chain = r;
        end else begin
            e = r ^ md_chain;
            md_chain = d;
        end
        if (last) md_chain = md_iv;
        exp_data.push_back(e);
        exp_last.push_back(last);
        return cin;
    endfunction

    // AES core stand-in: answers core_init with core_ready and core_next with a result.
    initial begin
        int kdue;
        int rdue;
        logic [127:0] rval;
        kdue = -1;
        rdue = -1;
        rval = '0;
        core_ready = 1'b0;
        core_result_valid = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #1;
            core_ready = 1'b0;
            core_result_valid = 1'b0;
            core_result = r128();
            if (!rst_n) begin
                kdue = -1;
                rdue = -1;
            end else begin
                if (cyc == kdue) begin
                    core_ready = 1'b1;
                    kready_cyc = cyc;
                    kdue = -1;
                end
                if (cyc == rdue) begin
                    core_result_valid = 1'b1;
                    core_result = rval;
                    rdue = -1;
                end
                if (core_init && core_ready_en) kdue = cyc + int'($urandom_range(1, 8));
                if (core_next) begin
                    n_next++;
                    if (core_result_en) begin
                        rdue = cyc + (rlat_fix > 0 ? rlat_fix : int'($urandom_range(1, 6)));
                        rval = core_fn(core_key, core_keylen, core_encdec, core_block);
                    end
                end
            end
        end
    end

    // Output sink and compare process: backpressure, stability and scoreboard checks.
    initial begin
        bit hold;
        bit fresh;
        int rem;
        logic [127:0] hold_d;
        logic hold_l;
        hold = 1'b0;
        fresh = 1'b1;
        rem = 0;
        hold_d = '0;
        hold_l = 1'b0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ready = 1'b0;
                hold = 1'b0;
                fresh = 1'b1;
                continue;
            end
            if (hold) check("m_valid held under backpressure", m_valid, 1'b1);
            if (!m_valid) begin
                m_ready = 1'b0;
                hold = 1'b0;
                fresh = 1'b1;
                continue;
            end
            if (hold) begin
                check("m_data stable", m_data, hold_d);
                check("m_last stable", m_last, hold_l);
            end
            check("s_ready low while output pending", s_ready, 1'b0);
            check("busy while output pending", busy, 1'b1);
            if (fresh) begin
                rem = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
                fresh = 1'b0;
            end
            if (rem > 0) begin
                rem--;
                m_ready = 1'b0;
                hold = 1'b1;
                hold_d = m_data;
                hold_l = m_last;
            end else begin
                m_ready = 1'b1;
                hold = 1'b0;
                fresh = 1'b1;
                outs.push_back(m_data);
                outs_last.push_back(m_last);
                check("output expected by model", exp_data.size() > 0, 1'b1);
                if (exp_data.size() > 0) begin
                    check("m_data vs model", m_data, exp_data.pop_front());
                    check("m_last vs model", m_last, exp_last.pop_front());
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, " flags"}, {key_ready, busy, err, s_ready, m_valid, m_last,
                                core_init, core_next, core_encdec, core_keylen}, '0);
        check({tag, " m_data"}, m_data, '0);
        check({tag, " core_block"}, core_block, '0);
        check({tag, " core_key"}, core_key, '0);
    endtask

    task automatic iv_load(input logic [127:0] iv);
        @(negedge clk);
        cfg_iv = iv;
        cfg_iv_load = 1'b1;
        @(negedge clk);
        cfg_iv_load = 1'b0;
        cfg_iv = r128();
        md_iv = iv;
        md_chain = iv;
    endtask

    task automatic key_load(input logic [255:0] k, input logic kl, input logic mode,
                            input logic enc, input bit expect_ready);
        int n;
        @(negedge clk);
        cfg_key = k;
        cfg_keylen = kl;
        cfg_mode = mode;
        cfg_encdec = enc;
        cfg_key_load = 1'b1;
        @(negedge clk);
        cfg_key_load = 1'b0;
        cfg_key = {r128(), r128()};
        cfg_keylen = ~kl;
        cfg_mode = ~mode;
        cfg_encdec = ~enc;
        md_key = k;
        md_kl = kl;
        md_mode = mode;
        md_enc = enc;
        md_chain = md_iv;
        check("core_init one cycle after load", core_init, 1'b1);
        check("err cleared by key load", err, 1'b0);
        check("key_ready cleared by key load", key_ready, 1'b0);
        check("core_key latched", core_key, k);
        check("core_keylen/encdec latched", {core_keylen, core_encdec}, {kl, enc});
        @(negedge clk);
        check("core_init single pulse", core_init, 1'b0);
        if (expect_ready) begin
            n = 0;
            while (!key_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("key_ready reached", key_ready, 1'b1);
            check("key_ready one cycle after core_ready", cyc, kready_cyc + 1);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic last, input bit use_model);
        int n;
        logic [127:0] cin;
        @(negedge clk);
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        n = 0;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("s_ready within budget", s_ready, 1'b1);
        if (!s_ready) begin
            s_valid = 1'b0;
            return;
        end
        cin = '0;
        if (use_model) cin = model_push(d, last);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data = r128();
        s_last = $urandom_range(0, 1) == 1;
        check("core_next the cycle after accept", core_next, 1'b1);
        check("s_ready drops after accept", s_ready, 1'b0);
        if (use_model) check("core_block", core_block, cin);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_data.size() != 0 || m_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("outputs drained", exp_data.size(), 0);
    endtask

    task automatic check_out(input string name, input int idx, input logic [127:0] exp,
                             input logic exp_l);
        check({name, " present"}, outs.size() > idx, 1'b1);
        if (outs.size() > idx) begin
            check(name, outs[idx], exp);
            check({name, " last"}, outs_last[idx], exp_l);
        end
    endtask

    // Global bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL global timeout: got no finish, expected finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int next0;
        cfg_key_load = 1'b0;
        cfg_key = '0;
        cfg_keylen = 1'b0;
        cfg_mode = 1'b0;
        cfg_encdec = 1'b0;
        cfg_iv_load = 1'b0;
        cfg_iv = '0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after reset release");

        // AES-128 ECB encrypt
        outs.delete();
        outs_last.delete();
        key_load({K1, r128()}, 1'b0, 1'b0, 1'b1, 1'b1);
        next0 = n_next;
        send(PT0, 1'b1, 1'b1);
        drain();
        check_out("ecb128 encrypt", 0, CT1, 1'b1);
        check("one core_next per block", n_next - next0, 1);

        // AES-256 ECB decrypt
        outs.delete();
        outs_last.delete();
        key_load(K2, 1'b1, 1'b0, 1'b0, 1'b1);
        send(CT2, 1'b1, 1'b1);
        drain();
        check_out("ecb256 decrypt", 0, PT0, 1'b1);

        // CBC encrypt, two-block message
        outs.delete();
        outs_last.delete();
        iv_load(IV3);
        key_load({K3, r128()}, 1'b0, 1'b1, 1'b1, 1'b1);
        send(P1, 1'b0, 1'b1);
        send(P2, 1'b1, 1'b1);
        drain();
        check_out("cbc enc block1", 0, C1, 1'b0);
        check_out("cbc enc block2", 1, C2, 1'b1);

        // CBC decrypt with 10 cycles of backpressure per block
        outs.delete();
        outs_last.delete();
        stall_n = 10;
        key_load({K3, r128()}, 1'b0, 1'b1, 1'b0, 1'b1);
        send(C1, 1'b0, 1'b1);
        send(C2, 1'b1, 1'b1);
        drain();
        stall_n = -1;
        check_out("cbc dec block1", 0, P1, 1'b0);
        check_out("cbc dec block2", 1, P2, 1'b1);

        // Chain returns to the IV after a last block
        outs.delete();
        outs_last.delete();
        key_load({K3, r128()}, 1'b0, 1'b1, 1'b1, 1'b1);
        send(P1, 1'b1, 1'b1);
        send(P1, 1'b1, 1'b1);
        drain();
        check_out("iv restart msg1", 0, C1, 1'b1);
        check_out("iv restart msg2", 1, C1, 1'b1);

        // Randomized configurations and messages
        for (int c = 0; c < 8; c++) begin
            int nb;
            logic kl;
            logic md;
            logic en;
            kl = $urandom_range(0, 1) == 1;
            md = $urandom_range(0, 1) == 1;
            en = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) iv_load(r128());
            key_load({r128(), r128()}, kl, md, en, 1'b1);
            nb = $urandom_range(3, 8);
            for (int b = 0; b < nb; b++) begin
                send(r128(), (b == nb - 1) || ($urandom_range(0, 3) == 0), 1'b1);
            end
            drain();
            if ($urandom_range(0, 1) == 1) begin
                iv_load(r128());
                send(r128(), 1'b0, 1'b1);
                send(r128(), 1'b1, 1'b1);
                drain();
            end
        end

        // Watchdog in KEYEXP
        core_ready_en = 1'b0;
        key_load({r128(), r128()}, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 1;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("keyexp timeout latency", n, TO);
        check("keyexp timeout flags", {err, key_ready, busy, s_ready}, 4'b1000);
        core_ready_en = 1'b1;

        // Watchdog in WAIT drops the block
        key_load({r128(), r128()}, 1'b0, 1'b0, 1'b1, 1'b1);
        core_result_en = 1'b0;
        send(r128(), 1'b1, 1'b0);
        n = 0;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait timeout latency", n, TO + 2);
        check("wait timeout flags", {err, key_ready, busy, s_ready, m_valid}, 5'b10000);
        repeat (5) @(negedge clk);
        check("dropped block never emerges", m_valid, 1'b0);
        core_result_en = 1'b1;

        // Reset while WAITing for a result
        key_load({r128(), r128()}, 1'b1, 1'b1, 1'b1, 1'b1);
        rlat_fix = 12;
        send(r128(), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("busy in WAIT", busy, 1'b1);
        rst_n = 1'b0;
        #1 check_zero("reset in WAIT");
        md_iv = '0;
        md_chain = '0;
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rlat_fix = 0;
        @(negedge clk);
        check("key_ready low after reset", key_ready, 1'b0);
        // After reset the chain and IV are zero.
        key_load({r128(), r128()}, 1'b0, 1'b1, 1'b1, 1'b1);
        send(r128(), 1'b0, 1'b1);
        send(r128(), 1'b1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
